// File: rtl/eeg_xram_pkg.sv
// Shared definitions for the XRAM read-port arbiter: default widths and FSM states.
package eeg_xram_pkg;

    localparam int XRAM_REQ_NUM_DEF = 2;
    localparam int XRAM_ADD_AW_DEF  = 12;
    localparam int XRAM_DAT_DW_DEF  = 8;

    // IDLE: no burst locked, BURST: bank port locked on one requester
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } xram_arb_st_e;

endpackage

// File: rtl/eeg_xram_arb_rr.sv
// Round-robin selector: first asserted request at or after ptr, wrapping N-1 -> 0.
module cpm_rr_arb #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_oh,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    // Requests at or above the pointer get first pick, the rest only on wrap
    logic [N-1:0] req_hi;

    for (genvar gi = 0; gi < N; gi++) begin : g_mask
        assign req_hi[gi] = req[gi] & (IW'(gi) >= ptr);
    end

    // Lowest set bit of the upper half wins, otherwise lowest set bit overall
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = ptr;
        any     = |req;
        if (|req_hi) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req_hi[i]) begin
                    gnt_oh  = '0;
                    gnt_oh[i] = 1'b1;
                    gnt_idx = IW'(i);
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req[i]) begin
                    gnt_oh  = '0;
                    gnt_oh[i] = 1'b1;
                    gnt_idx = IW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/eeg_xram_arb.sv
// Burst-locking round-robin arbiter sharing one XRAM bank read port between requesters.
module eeg_xram_arb
    import eeg_xram_pkg::*;
#(
    parameter int XRAM_REQ_NUM = XRAM_REQ_NUM_DEF,
    parameter int XRAM_ADD_AW  = XRAM_ADD_AW_DEF,
    parameter int XRAM_DAT_DW  = XRAM_DAT_DW_DEF
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [XRAM_REQ_NUM-1:0]                  REQ_ADD_VLD,
    input  logic [XRAM_REQ_NUM-1:0]                  REQ_ADD_LST,
    output logic [XRAM_REQ_NUM-1:0]                  REQ_ADD_RDY,
    input  logic [XRAM_REQ_NUM-1:0][XRAM_ADD_AW-1:0] REQ_ADD_ADD,
    output logic [XRAM_REQ_NUM-1:0]                  REQ_DAT_VLD,
    output logic [XRAM_REQ_NUM-1:0]                  REQ_DAT_LST,
    input  logic [XRAM_REQ_NUM-1:0]                  REQ_DAT_RDY,
    output logic [XRAM_REQ_NUM-1:0][XRAM_DAT_DW-1:0] REQ_DAT_DAT,
    output logic                                     RAM_ADD_VLD,
    output logic                                     RAM_ADD_LST,
    input  logic                                     RAM_ADD_RDY,
    output logic [XRAM_ADD_AW-1:0]                   RAM_ADD_ADD,
    input  logic                                     RAM_DAT_VLD,
    input  logic                                     RAM_DAT_LST,
    output logic                                     RAM_DAT_RDY,
    input  logic [XRAM_DAT_DW-1:0]                   RAM_DAT_DAT
);

    localparam int N  = XRAM_REQ_NUM;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    xram_arb_st_e  state_reg;
    logic [IW-1:0] gnt_q;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] own_q;

    logic [N-1:0]  win_oh;
    logic [IW-1:0] win_idx;
    logic          win_any;

    logic [N-1:0]  gnt_oh;
    logic [N-1:0]  sel_oh;
    logic [IW-1:0] sel_idx;
    logic          sel_vld;
    logic          add_acc;

    cpm_rr_arb #(
        .N  (N),
        .IW (IW)
    ) u_rr (
        .req     (REQ_ADD_VLD),
        .ptr     (rr_ptr),
        .gnt_oh  (win_oh),
        .gnt_idx (win_idx),
        .any     (win_any)
    );

    // Pointer advance modulo the requester count
    function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] v);
        if (int'(v) == N - 1) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

    for (genvar gi = 0; gi < N; gi++) begin : g_req
        assign gnt_oh[gi]      = (gnt_q == IW'(gi));
        assign REQ_ADD_RDY[gi] = RAM_ADD_RDY & sel_oh[gi];
        assign REQ_DAT_VLD[gi] = RAM_DAT_VLD & (own_q == IW'(gi));
        assign REQ_DAT_LST[gi] = RAM_DAT_LST & (own_q == IW'(gi));
        assign REQ_DAT_DAT[gi] = RAM_DAT_DAT;
    end

    // While locked the granted requester owns the port even when it bubbles
    always_comb begin
        sel_oh  = win_oh;
        sel_idx = win_idx;
        sel_vld = win_any;
        if (state_reg == BURST) begin
            sel_oh  = gnt_oh;
            sel_idx = gnt_q;
            sel_vld = REQ_ADD_VLD[gnt_q];
        end
    end

    assign RAM_ADD_VLD = sel_vld;
    assign RAM_ADD_LST = REQ_ADD_LST[sel_idx];
    assign RAM_ADD_ADD = REQ_ADD_ADD[sel_idx];
    assign RAM_DAT_RDY = REQ_DAT_RDY[own_q];
    assign add_acc     = sel_vld & RAM_ADD_RDY;

    // Burst lock FSM, round-robin pointer and return-data owner tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            gnt_q     <= '0;
            rr_ptr    <= '0;
            own_q     <= '0;
        end else begin
            // The bank output register reloads exactly when RAM_ADD_RDY is high
            if (RAM_ADD_RDY) begin
                own_q <= sel_idx;
            end
            if (add_acc) begin
                case (state_reg)
                    IDLE: begin
                        if (RAM_ADD_LST) begin
                            rr_ptr <= inc_mod(win_idx);
                        end else begin
                            state_reg <= BURST;
                            gnt_q     <= win_idx;
                        end
                    end
                    BURST: begin
                        if (RAM_ADD_LST) begin
                            state_reg <= IDLE;
                            rr_ptr    <= inc_mod(gnt_q);
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eeg_xram_arb.sv
// Directed bench for eeg_xram_arb with a one-cycle-latency bank model.
module tb_eeg_xram_arb;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       add_vld;
    logic [1:0]       add_lst;
    logic [1:0]       add_rdy;
    logic [1:0][11:0] add_add;
    logic [1:0]       dat_vld;
    logic [1:0]       dat_lst;
    logic [1:0]       dat_rdy;
    logic [1:0][7:0]  dat_dat;
    logic             ram_add_vld;
    logic             ram_add_lst;
    logic             ram_add_rdy;
    logic [11:0]      ram_add_add;
    logic             ram_dat_rdy;
    logic             bank_vld;
    logic             bank_lst;
    logic [7:0]       bank_dat;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    eeg_xram_arb #(
        .XRAM_REQ_NUM (2),
        .XRAM_ADD_AW  (12),
        .XRAM_DAT_DW  (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .REQ_ADD_VLD (add_vld),
        .REQ_ADD_LST (add_lst),
        .REQ_ADD_RDY (add_rdy),
        .REQ_ADD_ADD (add_add),
        .REQ_DAT_VLD (dat_vld),
        .REQ_DAT_LST (dat_lst),
        .REQ_DAT_RDY (dat_rdy),
        .REQ_DAT_DAT (dat_dat),
        .RAM_ADD_VLD (ram_add_vld),
        .RAM_ADD_LST (ram_add_lst),
        .RAM_ADD_RDY (ram_add_rdy),
        .RAM_ADD_ADD (ram_add_add),
        .RAM_DAT_VLD (bank_vld),
        .RAM_DAT_LST (bank_lst),
        .RAM_DAT_RDY (ram_dat_rdy),
        .RAM_DAT_DAT (bank_dat)
    );

    // Bank: output register loads one cycle after the address handshake
    assign ram_add_rdy = ram_dat_rdy | ~bank_vld;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_vld <= 1'b0;
            bank_lst <= 1'b0;
            bank_dat <= 8'h00;
        end else if (ram_add_rdy) begin
            bank_vld <= ram_add_vld;
            bank_lst <= ram_add_lst;
            bank_dat <= ram_add_add[7:0] ^ 8'h5A;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        add_vld = 2'b00;
        add_lst = 2'b00;
        add_add = '0;
        dat_rdy = 2'b10;

        // Reset state: nothing forwarded, owner is requester 0
        @(negedge clk);
        chk("rst_ram_vld", ram_add_vld, 0);
        chk("rst_dat_vld", dat_vld, 2'b00);
        chk("rst_dat_rdy", ram_dat_rdy, 0);
        chk("rst_add_rdy", ram_add_rdy, 1);
        nxt();
        dat_rdy = 2'b11;
        rst_n   = 1'b1;

        // Alternating single beats: grants 0,1,0,1, data one cycle later
        add_vld = 2'b11; add_lst = 2'b11;
        add_add[0] = 12'h111; add_add[1] = 12'h222;
        @(negedge clk);
        chk("rr_c0_rdy", add_rdy, 2'b01);
        chk("rr_c0_add", ram_add_add, 12'h111);
        chk("rr_c0_dvld", dat_vld, 2'b00);
        nxt();
        @(negedge clk);
        chk("rr_c1_rdy", add_rdy, 2'b10);
        chk("rr_c1_add", ram_add_add, 12'h222);
        chk("rr_c1_dvld", dat_vld, 2'b01);
        chk("rr_c1_dat", dat_dat[0], 8'h4B);
        chk("rr_c1_dlst", dat_lst, 2'b01);
        nxt();
        @(negedge clk);
        chk("rr_c2_rdy", add_rdy, 2'b01);
        chk("rr_c2_dvld", dat_vld, 2'b10);
        chk("rr_c2_dat", dat_dat[1], 8'h78);
        nxt();
        @(negedge clk);
        chk("rr_c3_rdy", add_rdy, 2'b10);
        chk("rr_c3_dvld", dat_vld, 2'b01);
        nxt();
        add_vld = 2'b00;
        @(negedge clk);
        chk("rr_c4_dvld", dat_vld, 2'b10);
        chk("rr_c4_rvld", ram_add_vld, 0);
        nxt();

        // 4-beat burst on req0 while req1 waits; req1 granted on cycle 5
        add_vld = 2'b11; add_lst = 2'b10;
        add_add[0] = 12'h010; add_add[1] = 12'h222;
        @(negedge clk);
        chk("bu_b0_rdy", add_rdy, 2'b01);
        chk("bu_b0_add", ram_add_add, 12'h010);
        chk("bu_b0_lst", ram_add_lst, 0);
        nxt();
        add_add[0] = 12'h011;
        @(negedge clk);
        chk("bu_b1_rdy", add_rdy, 2'b01);
        chk("bu_b1_add", ram_add_add, 12'h011);
        chk("bu_b1_dat", dat_dat[0], 8'h4A);
        chk("bu_b1_dlst", dat_lst, 2'b00);
        nxt();
        add_add[0] = 12'h012;
        @(negedge clk);
        chk("bu_b2_rdy", add_rdy, 2'b01);
        chk("bu_b2_add", ram_add_add, 12'h012);
        chk("bu_b2_dat", dat_dat[0], 8'h4B);
        nxt();
        add_add[0] = 12'h013; add_lst = 2'b11;
        @(negedge clk);
        chk("bu_b3_rdy", add_rdy, 2'b01);
        chk("bu_b3_lst", ram_add_lst, 1);
        nxt();
        add_vld = 2'b10;
        @(negedge clk);
        chk("bu_b4_rdy", add_rdy, 2'b10);
        chk("bu_b4_add", ram_add_add, 12'h222);
        chk("bu_b4_dvld", dat_vld, 2'b01);
        chk("bu_b4_dat", dat_dat[0], 8'h49);
        chk("bu_b4_dlst", dat_lst, 2'b01);
        nxt();
        add_vld = 2'b00; add_lst = 2'b00;
        @(negedge clk);
        chk("bu_b5_dvld", dat_vld, 2'b10);
        chk("bu_b5_dlst", dat_lst, 2'b10);
        nxt();

        // Owner back-pressure stalls the bank address port for 3 cycles
        add_vld = 2'b01; add_lst = 2'b11; add_add[0] = 12'h033;
        dat_rdy = 2'b10;
        @(negedge clk);
        chk("st_s0_rdy", add_rdy, 2'b01);
        nxt();
        add_vld = 2'b11; add_add[0] = 12'h034; add_add[1] = 12'h044;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("st_h%0d_ramrdy", i), ram_add_rdy, 0);
            chk($sformatf("st_h%0d_rdy", i), add_rdy, 2'b00);
            chk($sformatf("st_h%0d_dvld", i), dat_vld, 2'b01);
            chk($sformatf("st_h%0d_dat", i), dat_dat[0], 8'h69);
            nxt();
        end
        dat_rdy = 2'b11;
        @(negedge clk);
        chk("st_s4_rdy", add_rdy, 2'b10);
        chk("st_s4_add", ram_add_add, 12'h044);
        chk("st_s4_dvld", dat_vld, 2'b01);
        nxt();
        add_vld = 2'b01;
        @(negedge clk);
        chk("st_s5_rdy", add_rdy, 2'b01);
        chk("st_s5_add", ram_add_add, 12'h034);
        chk("st_s5_dvld", dat_vld, 2'b10);
        chk("st_s5_dat", dat_dat[1], 8'h1E);
        nxt();
        add_vld = 2'b00;
        @(negedge clk);
        chk("st_s6_dvld", dat_vld, 2'b01);
        chk("st_s6_dat", dat_dat[0], 8'h6E);
        nxt();

        // Locked requester bubbles for 2 cycles; the waiting one is not served
        add_vld = 2'b11; add_lst = 2'b01;
        add_add[0] = 12'h060; add_add[1] = 12'h050;
        @(negedge clk);
        chk("lk_m0_rdy", add_rdy, 2'b10);
        chk("lk_m0_add", ram_add_add, 12'h050);
        nxt();
        add_vld = 2'b01;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("lk_b%0d_rvld", i), ram_add_vld, 0);
            chk($sformatf("lk_b%0d_rdy", i), add_rdy, 2'b10);
            nxt();
        end
        add_vld = 2'b11; add_add[1] = 12'h051;
        @(negedge clk);
        chk("lk_m3_rdy", add_rdy, 2'b10);
        chk("lk_m3_add", ram_add_add, 12'h051);
        nxt();
        add_add[1] = 12'h052; add_lst = 2'b11;
        @(negedge clk);
        chk("lk_m4_rdy", add_rdy, 2'b10);
        chk("lk_m4_lst", ram_add_lst, 1);
        nxt();
        add_vld = 2'b01;
        @(negedge clk);
        chk("lk_m5_rdy", add_rdy, 2'b01);
        chk("lk_m5_add", ram_add_add, 12'h060);
        nxt();
        add_vld = 2'b00;
        nxt();

        // Reset after 2 of 4 beats drops the lock; req1 alone granted at once
        add_vld = 2'b01; add_lst = 2'b00; add_add[0] = 12'h080;
        @(negedge clk);
        chk("rb_r0_rdy", add_rdy, 2'b01);
        nxt();
        add_add[0] = 12'h081;
        @(negedge clk);
        chk("rb_r1_rdy", add_rdy, 2'b01);
        nxt();
        add_add[0] = 12'h082;
        rst_n = 1'b0;
        #1;
        chk("rb_rst_dvld", dat_vld, 2'b00);
        chk("rb_rst_drdy", ram_dat_rdy, 1);
        #1;
        add_vld = 2'b10; add_lst = 2'b10; add_add[1] = 12'h090;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rb_a0_vld", ram_add_vld, 1);
        chk("rb_a0_rdy", add_rdy, 2'b10);
        chk("rb_a0_add", ram_add_add, 12'h090);
        nxt();
        add_vld = 2'b11; add_lst = 2'b11;
        add_add[0] = 12'h0A0; add_add[1] = 12'h0A1;
        @(negedge clk);
        chk("rb_a1_dvld", dat_vld, 2'b10);
        chk("rb_a1_dat", dat_dat[1], 8'hCA);
        chk("rb_a1_rdy", add_rdy, 2'b01);
        nxt();
        add_vld = 2'b00;
        nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
